// File: rtl/sd_request_arbiter_if.sv
// ----------------------------------------------------------------------------
// sd_request_arbiter_if
//
// Bundles the requester-side and io-controller-side signals of the SD image
// request arbiter.
//
//   req_rd/req_wr   one-cycle read/write request pulses, one bit per requester
//   req_lba         flattened LBAs, LBA_W bits per requester
//   req_data        flattened write-data bytes, 8 bits per requester
//   req_busy        io-controller busy routed to the granted requester
//   req_done        one-cycle completion pulse to the granted requester
//   req_err         one-cycle timeout pulse, coincident with req_done
//   sdc_lba         LBA presented to the io controller
//   sdc_rd/sdc_wr   read/write strobes, one bit per image slot
//   sdc_busy        io controller busy
//   sdc_done        io controller done pulse
//   sdc_data_out    write data taken from the granted requester
//   grant_valid     a transfer is in service
//   grant_idx       index of the granted requester
//
// Modports: slave = arbiter side, master = requesters plus io controller.
// ----------------------------------------------------------------------------
interface sd_request_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int LBA_W = 32
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_rd;
    logic [NREQ-1:0]       req_wr;
    logic [NREQ*LBA_W-1:0] req_lba;
    logic [NREQ*8-1:0]     req_data;
    logic [NREQ-1:0]       req_busy;
    logic [NREQ-1:0]       req_done;
    logic [NREQ-1:0]       req_err;
    logic [LBA_W-1:0]      sdc_lba;
    logic [NREQ-1:0]       sdc_rd;
    logic [NREQ-1:0]       sdc_wr;
    logic                  sdc_busy;
    logic                  sdc_done;
    logic [7:0]            sdc_data_out;
    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;

    modport slave (
        input  req_rd, req_wr, req_lba, req_data, sdc_busy, sdc_done,
        output req_busy, req_done, req_err, sdc_lba, sdc_rd, sdc_wr,
               sdc_data_out, grant_valid, grant_idx
    );

    modport master (
        output req_rd, req_wr, req_lba, req_data, sdc_busy, sdc_done,
        input  req_busy, req_done, req_err, sdc_lba, sdc_rd, sdc_wr,
               sdc_data_out, grant_valid, grant_idx
    );
endinterface

// File: rtl/sd_request_arbiter.sv
// ----------------------------------------------------------------------------
// sd_request_arbiter
//
// Shares the single SD-card image interface between the floppy drives
// (requesters 0/1) and the SCSI targets (requesters 2..NREQ-1). Requests are
// latched per requester, granted round-robin, presented to the io controller
// with the LBA one cycle ahead of the strobe, and busy/done/write data are
// routed to and from the granted requester only.
//
// Ports:
//   clk     system clock
//   _reset  asynchronous active-low reset
//   bus     sd_request_arbiter_if.slave (request, io-controller and grant
//           signals)
//
// Optional feature macro: SDARB_TIMEOUT_EN
//   defined   24-bit watchdog in STROBE/WAIT; on expiry the transfer ends
//             with req_err pulsed alongside req_done
//   undefined the FSM waits indefinitely and req_err is tied to 0
// ----------------------------------------------------------------------------
module sd_request_arbiter #(
    parameter int NREQ  = 4,
    parameter int LBA_W = 32
) (
    input  logic                 clk,
    input  logic                 _reset,
    sd_request_arbiter_if.slave  bus
);
    localparam int               IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_STROBE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_d;

    logic [NREQ-1:0]  pend;
    logic [NREQ-1:0]  op;           // 0 = read, 1 = write
    logic [LBA_W-1:0] lba_q [NREQ];

    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;
    logic             grant_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] rr_cand;
    logic             pick_found;

    logic [LBA_W-1:0] sdc_lba_q;
    logic [NREQ-1:0]  sdc_rd_q;
    logic [NREQ-1:0]  sdc_wr_q;
    logic [NREQ-1:0]  req_done_q;
    logic [NREQ-1:0]  req_busy_c;
    logic [NREQ-1:0]  rd_d;
    logic [NREQ-1:0]  wr_d;
    logic [NREQ-1:0]  done_d;
    logic             timeout_hit;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef SDARB_TIMEOUT_EN
    logic [23:0]      wdog;
    logic [NREQ-1:0]  err_d;
    logic [NREQ-1:0]  req_err_q;

    // Cleared while in ISSUE so it reads zero in the first STROBE cycle.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wdog <= '0;
        end else if (state == S_ISSUE) begin
            wdog <= '0;
        end else if (state == S_STROBE || state == S_WAIT) begin
            wdog <= wdog + 24'd1;
        end
    end

    assign timeout_hit = (state == S_STROBE || state == S_WAIT) && (wdog == '1);
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Round-robin pick: search starts one past the last grant and wraps.
    // ------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            rr_cand = IDX_W'((32'(last_grant) + k) % NREQ);
            if (!pick_found && pend[rr_cand]) begin
                pick_found = 1'b1;
                pick_idx   = rr_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending latches. A read wins over a simultaneous write; pulses from a
    // requester that is pending or in service are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            pend <= '0;
            op   <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                lba_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (state == S_IDLE && pick_found && pick_idx == IDX_W'(i)) begin
                    pend[i] <= 1'b0;
                end else if ((bus.req_rd[i] || bus.req_wr[i]) && !pend[i] &&
                             !(grant_valid && grant_idx == IDX_W'(i))) begin
                    pend[i]  <= 1'b1;
                    op[i]    <= !bus.req_rd[i];
                    lba_q[i] <= bus.req_lba[i*LBA_W +: LBA_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (pick_found) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_STROBE;
            S_STROBE: begin
                if (bus.sdc_done || timeout_hit) state_d = S_DONE;
                else if (bus.sdc_busy)           state_d = S_WAIT;
            end
            S_WAIT:   if (bus.sdc_done || !bus.sdc_busy || timeout_hit) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. These are the D inputs of the registered outputs, so the
    // strobe rises on entry to STROBE and falls on the edge that leaves it.
    // ------------------------------------------------------------------
    always_comb begin
        rd_d   = '0;
        wr_d   = '0;
        done_d = '0;
`ifdef SDARB_TIMEOUT_EN
        err_d  = '0;
`endif
        if (state == S_ISSUE || (state == S_STROBE && state_d == S_STROBE)) begin
            if (op[grant_idx]) wr_d[grant_idx] = 1'b1;
            else               rd_d[grant_idx] = 1'b1;
        end
        if (state_d == S_DONE && state != S_DONE) begin
            done_d[grant_idx] = 1'b1;
`ifdef SDARB_TIMEOUT_EN
            err_d[grant_idx]  = timeout_hit;
`endif
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sdc_rd_q    <= '0;
            sdc_wr_q    <= '0;
            req_done_q  <= '0;
            sdc_lba_q   <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            last_grant  <= LAST_IDX;
`ifdef SDARB_TIMEOUT_EN
            req_err_q   <= '0;
`endif
        end else begin
            sdc_rd_q   <= rd_d;
            sdc_wr_q   <= wr_d;
            req_done_q <= done_d;
`ifdef SDARB_TIMEOUT_EN
            req_err_q  <= err_d;
`endif
            if (state == S_IDLE && pick_found) begin
                grant_idx   <= pick_idx;
                grant_valid <= 1'b1;
                sdc_lba_q   <= lba_q[pick_idx];
            end
            if (state == S_DONE) begin
                grant_valid <= 1'b0;
                last_grant  <= grant_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Routing
    // ------------------------------------------------------------------
    always_comb begin
        req_busy_c = '0;
        if (grant_valid) req_busy_c[grant_idx] = bus.sdc_busy;
    end

    assign bus.req_busy     = req_busy_c;
    assign bus.req_done     = req_done_q;
    assign bus.sdc_lba      = sdc_lba_q;
    assign bus.sdc_rd       = sdc_rd_q;
    assign bus.sdc_wr       = sdc_wr_q;
    assign bus.grant_valid  = grant_valid;
    assign bus.grant_idx    = grant_idx;
    assign bus.sdc_data_out = grant_valid ? bus.req_data[32'(grant_idx)*8 +: 8]
                                          : bus.req_data[7:0];
`ifdef SDARB_TIMEOUT_EN
    assign bus.req_err      = req_err_q;
`else
    assign bus.req_err      = '0;
`endif

endmodule

// File: tb/tb_sd_request_arbiter.sv
module tb_sd_request_arbiter;
    localparam int NREQ  = 4;
    localparam int LBA_W = 32;

    logic clk = 1'b0;
    logic _reset;

    always #5 clk = ~clk;

    sd_request_arbiter_if #(.NREQ(NREQ), .LBA_W(LBA_W)) bus ();

    sd_request_arbiter #(.NREQ(NREQ), .LBA_W(LBA_W)) dut (
        .clk    (clk),
        ._reset (_reset),
        .bus    (bus)
    );

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] lba;
        logic [7:0]  data;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] m_busy;
    int         m_last;
    logic [7:0] data_tbl[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(1) << i;
    endfunction

    // Pulse requests for one cycle; model queues accepted ones in round-robin order.
    task automatic request(input logic [3:0] rd, input logic [3:0] wr);
        logic [31:0] lv[4];
        int          c;
        exp_t        e;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            lv[i] = $urandom;
            bus.req_lba[i*32 +: 32] = lv[i];
        end
        bus.req_rd = rd;
        bus.req_wr = wr;
        for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if ((((rd | wr) & oh(c)) != 0) && ((m_busy & oh(c)) == 0)) begin
                e.idx  = c;
                e.wr   = ((rd & oh(c)) == 0);
                e.lba  = lv[c];
                e.data = data_tbl[c];
                sb.push_back(e);
                m_busy = m_busy | oh(c);
            end
        end
        @(posedge clk); #1;
        bus.req_rd = '0;
        bus.req_wr = '0;
    endtask

    // Act as io controller for one transfer.
    // mode 0: busy then busy falls; 1: done pulse in STROBE; 2: busy then done pulse.
    task automatic serve_one(input int mode, input int hold, input logic [3:0] repulse);
        exp_t       e;
        int         n;
        logic [3:0] st;
        logic       seen;
        n = 0;
        @(negedge clk);
        while ((bus.sdc_rd | bus.sdc_wr) == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("strobe_seen", 32'((bus.sdc_rd | bus.sdc_wr) != 4'b0), 32'd1);
        if ((bus.sdc_rd | bus.sdc_wr) == 4'b0) return;
        check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e  = sb.pop_front();
        st = oh(e.idx);
        check_eq("rd_strobe", 32'(bus.sdc_rd), 32'(e.wr ? 4'b0 : st));
        check_eq("wr_strobe", 32'(bus.sdc_wr), 32'(e.wr ? st : 4'b0));
        check_eq("sdc_lba", bus.sdc_lba, e.lba);
        check_eq("data_out", 32'(bus.sdc_data_out), 32'(e.data));
        check_eq("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
        check_eq("grant_valid", 32'(bus.grant_valid), 32'd1);
        if (mode == 1) begin
            @(posedge clk); #1 bus.sdc_done = 1'b1;
            @(negedge clk);
            check_eq("strobe_hold", 32'(bus.sdc_rd | bus.sdc_wr), 32'(st));
            @(posedge clk); #1 bus.sdc_done = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.sdc_busy = 1'b1;
            bus.req_rd   = repulse;
            @(negedge clk);
            check_eq("req_busy", 32'(bus.req_busy), 32'(st));
            check_eq("strobe_hold", 32'(bus.sdc_rd | bus.sdc_wr), 32'(st));
            @(posedge clk); #1 bus.req_rd = '0;
            @(negedge clk);
            check_eq("strobe_drop", 32'(bus.sdc_rd | bus.sdc_wr), 32'd0);
            seen = 1'b0;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                seen = seen | (|bus.req_done);
            end
            @(posedge clk); #1;
            if (mode == 2) bus.sdc_done = 1'b1;
            else           bus.sdc_busy = 1'b0;
            @(negedge clk);
            seen = seen | (|bus.req_done);
            check_eq("early_done", 32'(seen), 32'd0);
            @(posedge clk); #1;
            bus.sdc_done = 1'b0;
            bus.sdc_busy = 1'b0;
        end
        @(negedge clk);
        check_eq("req_done", 32'(bus.req_done), 32'(st));
        check_eq("req_err", 32'(bus.req_err), 32'd0);
        check_eq("strobe_off", 32'(bus.sdc_rd | bus.sdc_wr), 32'd0);
        m_busy = m_busy & ~oh(e.idx);
        m_last = e.idx;
        @(negedge clk);
        check_eq("done_clear", 32'(bus.req_done), 32'd0);
        check_eq("grant_drop", 32'(bus.grant_valid), 32'd0);
    endtask

    task automatic idle_quiet(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            seen = seen | (|(bus.sdc_rd | bus.sdc_wr)) | (|bus.req_done);
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [3:0] rd;
        logic [3:0] wr;
        int         n;
        logic       seen;

        _reset       = 1'b0;
        bus.req_rd   = '0;
        bus.req_wr   = '0;
        bus.req_lba  = '0;
        bus.sdc_busy = 1'b0;
        bus.sdc_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_tbl[i] = 8'($urandom);
            bus.req_data[i*8 +: 8] = data_tbl[i];
        end
        m_busy = '0;
        m_last = 3;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_rd", 32'(bus.sdc_rd), 32'd0);
        check_eq("rst_wr", 32'(bus.sdc_wr), 32'd0);
        check_eq("rst_lba", bus.sdc_lba, 32'd0);
        check_eq("rst_busy", 32'(bus.req_busy), 32'd0);
        check_eq("rst_done", 32'(bus.req_done), 32'd0);
        check_eq("rst_err", 32'(bus.req_err), 32'd0);
        check_eq("rst_gvalid", 32'(bus.grant_valid), 32'd0);
        check_eq("rst_gidx", 32'(bus.grant_idx), 32'd0);
        check_eq("rst_data", 32'(bus.sdc_data_out), 32'(data_tbl[0]));
        @(posedge clk); #1 _reset = 1'b1;

        // Simultaneous: rd0, wr1, rd3 -> 0, 1, 3
        request(4'b1001, 4'b0010);
        serve_one(0, 2, 4'b0000);
        serve_one(1, 0, 4'b0000);
        serve_one(2, 1, 4'b0000);
        idle_quiet(4, "sim_quiet");

        // Round-robin fairness
        request(4'b1001, 4'b0000);
        serve_one(0, 1, 4'b0000);
        serve_one(1, 0, 4'b0000);
        request(4'b1001, 4'b0000);
        serve_one(1, 0, 4'b0000);
        serve_one(0, 0, 4'b0000);
        request(4'b0001, 4'b0000);
        serve_one(1, 0, 4'b0000);
        request(4'b1001, 4'b0000);
        serve_one(0, 1, 4'b0000);
        serve_one(1, 0, 4'b0000);

        // Single read with exact cycle timing (t = cycles after the pulse)
        for (int t = 0; t < 34; t++) begin
            @(posedge clk); #1;
            if (t == 0) begin
                bus.req_lba[2*32 +: 32] = 32'h0000_1234;
                bus.req_rd = 4'b0100;
            end else begin
                bus.req_rd = 4'b0000;
            end
            if (t == 4)  bus.sdc_busy = 1'b1;
            if (t == 30) bus.sdc_busy = 1'b0;
            @(negedge clk);
            if (t == 2 || t == 33) check_eq("sr_lba", bus.sdc_lba, 32'h0000_1234);
            check_eq("sr_rd", 32'(bus.sdc_rd), (t == 3 || t == 4) ? 32'h4 : 32'h0);
            check_eq("sr_busy", 32'(bus.req_busy), (t >= 4 && t <= 29) ? 32'h4 : 32'h0);
            check_eq("sr_done", 32'(bus.req_done), (t == 31) ? 32'h4 : 32'h0);
        end
        m_last = 2;

        // Conflicting pulses and re-pulse during service
        request(4'b0010, 4'b0010);
        serve_one(0, 2, 4'b0010);
        idle_quiet(12, "conflict_single_done");

        // Random mixes
        for (int r = 0; r < 8; r++) begin
            rd = 4'($urandom);
            wr = 4'($urandom);
            if ((rd | wr) == 4'b0) rd = 4'b0001;
            request(rd, wr);
            n = sb.size();
            for (int j = 0; j < n; j++) serve_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 4'b0000);
            idle_quiet(3, "rand_quiet");
        end

        // Reset abort during WAIT
        request(4'b0100, 4'b0000);
        n = 0;
        @(negedge clk);
        while ((bus.sdc_rd | bus.sdc_wr) == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("abort_strobe_seen", 32'(bus.sdc_rd), 32'h4);
        @(posedge clk); #1 bus.sdc_busy = 1'b1;
        @(posedge clk); #1;
        #2 _reset = 1'b0;
        #1;
        check_eq("abort_rd", 32'(bus.sdc_rd), 32'd0);
        check_eq("abort_wr", 32'(bus.sdc_wr), 32'd0);
        check_eq("abort_busy", 32'(bus.req_busy), 32'd0);
        check_eq("abort_done", 32'(bus.req_done), 32'd0);
        check_eq("abort_err", 32'(bus.req_err), 32'd0);
        check_eq("abort_gvalid", 32'(bus.grant_valid), 32'd0);
        check_eq("abort_gidx", 32'(bus.grant_idx), 32'd0);
        check_eq("abort_lba", bus.sdc_lba, 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | (|bus.req_done) | (|bus.req_busy);
        end
        check_eq("abort_no_done", 32'(seen), 32'd0);
        @(posedge clk); #1;
        _reset       = 1'b1;
        bus.sdc_busy = 1'b0;
        sb.delete();
        m_busy = '0;
        m_last = 3;
        idle_quiet(5, "abort_quiet");
        request(4'b0001, 4'b0000);
        serve_one(0, 1, 4'b0000);

`ifndef SDARB_TIMEOUT_EN
        // Busy held long: without the watchdog no done until busy falls
        request(4'b0000, 4'b1000);
        serve_one(0, 300, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sd_request_arbiter.md
# sd_request_arbiter

Shares the single SD-card image interface of the io controller between all block-level requesters: floppy drives 0/1 from the IWM and SCSI targets 0..SCSI_DEVS-1 from the NCR5380. It replaces the ad-hoc `scsi_io`/`scsi_dev` steering in the data controller with four mechanisms:
- per-requester request latching,
- round-robin arbitration,
- a sequenced LBA-before-strobe handshake,
- routing of busy, done and write data to and from the granted requester only.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters. Index 0/1 are the floppies; index 2.. are the SCSI targets. Index equals the image slot.
- `LBA_W`, default 32: LBA width. Narrower requester LBAs are zero-extended by the instantiator.

Ports:
- `clk`  in  1  system clock, 16 MHz pixel clock domain
- `_reset`  in  1  asynchronous, active-low reset
- `req_rd`  in  NREQ  one-cycle read-request pulse per requester
- `req_wr`  in  NREQ  one-cycle write-request pulse per requester
- `req_lba`  in  NREQ*LBA_W  flattened LBAs; slice i is sampled in the same cycle as requester i's pulse
- `req_data`  in  NREQ*8  flattened write-data bytes per requester
- `req_busy`  out  NREQ  `sdc_busy` routed to the granted requester; 0 elsewhere
- `req_done`  out  NREQ  one-cycle completion pulse to the granted requester
- `req_err`  out  NREQ  one-cycle timeout pulse, coincident with `req_done`
- `sdc_lba`  out  LBA_W  LBA to the io controller
- `sdc_rd`  out  NREQ  read strobe, one bit per image slot
- `sdc_wr`  out  NREQ  write strobe, one bit per image slot
- `sdc_busy`  in  1  io controller busy
- `sdc_done`  in  1  io controller done pulse
- `sdc_data_out`  out  8  write data, taken from `req_data` of the granted requester
- `grant_valid`  out  1  a transfer is in service
- `grant_idx`  out  $clog2(NREQ)  index of the granted requester

## Operation
- **Pending latches.** A pulse on `req_rd[i]` or `req_wr[i]` while requester i is neither pending nor granted does two things:
  - sets `pend[i]` and the op bit (rd=0, wr=1);
  - captures `req_lba[i]` into a per-requester LBA latch.
- **Pulse conflicts.**
  - `req_rd` and `req_wr` high together: the read is taken and the write is ignored.
  - A pulse while requester i is already pending or granted is ignored.
- **Arbitration.**
  - Round-robin in IDLE. Search starts at `last_grant+1` and wraps modulo NREQ.
  - `last_grant` resets to NREQ-1, so index 0 wins the first tie.
- **FSM states.**
  - IDLE: if any `pend` is set, latch `grant_idx`, clear `pend[g]`, go to ISSUE.
  - ISSUE: `sdc_lba` = latched LBA[g]; no strobe this cycle. Go to STROBE.
  - STROBE: assert `sdc_rd[g]` or `sdc_wr[g]` and hold it.
    - On sampled `sdc_busy`=1: deassert the strobe, go to WAIT.
    - On sampled `sdc_done`=1: go directly to DONE.
  - WAIT: on `sdc_done`=1, or on `sdc_busy` falling to 0, go to DONE.
  - DONE: pulse `req_done[g]`, set `last_grant`=g, drop `grant_valid`, go to IDLE.
- **Output stability.** `sdc_lba` holds its value from ISSUE until the next ISSUE. `sdc_rd`/`sdc_wr` are never both high, and at most one bit of each is set.
- **Routing.** `req_busy[g]` = `sdc_busy` while `grant_valid`; all other bits are 0. `sdc_data_out` = `req_data[g]` combinationally. It is `req_data[0]` when idle.
- **Reset values.** Asserting `_reset` mid-transfer aborts immediately with no done pulse. Every output resets to 0: strobes, busy/done/err, `sdc_lba`, `grant_valid`, `grant_idx`. All `pend` bits clear.

## Timing
- Pulse in cycle N sets `pend` at N+1. With the arbiter idle and no competitor:
  - ISSUE at N+2, when `sdc_lba` becomes valid;
  - strobe high from N+3.
  - `sdc_lba` is therefore stable at least one cycle before any strobe.
- The strobe falls in the cycle after `sdc_busy` is first sampled high.
- `req_done` is asserted one cycle after the completion condition is sampled.
- The next grant may enter ISSUE no earlier than two cycles after DONE.
- All outputs are registered except `sdc_data_out` and `req_busy`, which are combinational from the grant registers.

## Configuration
- `SDARB_TIMEOUT_EN` defined:
  - A 24-bit watchdog clears on entry to STROBE and counts in STROBE/WAIT.
  - At 24'hFFFFFF the strobe is dropped and DONE is entered with `req_err[g]` pulsed alongside `req_done[g]`.
- Not defined: the watchdog is absent, the FSM waits indefinitely in STROBE/WAIT, and `req_err` is tied to 0.

## Test plan
- **Single read.** `req_rd[2]` with LBA 0x1234 at cycle 10, host raises busy at 14 and drops it at 40:
  - `sdc_lba`=0x1234 at 12;
  - `sdc_rd`=4'b0100 during 13-14 only;
  - `req_busy[2]` high 14-39;
  - `req_done[2]` pulses at 41.
- **Simultaneous requests.** `req_rd[0]`, `req_wr[1]` and `req_rd[3]` all in one cycle → served in order 0, 1, 3. `sdc_wr[1]` is the only write strobe.
- **Round-robin fairness.** After servicing 3, re-pulse 0 and 3 together → 0 is served first. Repeat → order alternates correctly.
- **Conflicting pulses.** `req_rd[1]` and `req_wr[1]` in the same cycle → only `sdc_rd[1]` is asserted. A second `req_rd[1]` during service is ignored and yields exactly one `req_done`.
- **Reset abort.** `_reset` low during WAIT → all outputs 0 asynchronously and no `req_done`. After release, a fresh request completes normally.
- **Timeout.** With `SDARB_TIMEOUT_EN`, busy held high forever → `req_done` and `req_err` pulse together 2^24 cycles after STROBE entry. Without the macro, no done pulse occurs.
